// File: rtl/alarm_clock_core.sv
// HH:MM:SS timekeeper with settable alarm, ring/snooze FSM and a multiplexed
// seven-segment display driver, all clock-enabled from one fast clock.
module alarm_clock_core #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SCAN_DIV      = 125_000,
  parameter int DIGITS        = 4,
  parameter int RING_SECS     = 60,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        set_mode,
  input  logic              inc_hr,
  input  logic              inc_min,
  input  logic              alarm_en,
  input  logic              snooze,
  input  logic              stop,
  output logic [4:0]        hours,
  output logic [5:0]        minutes,
  output logic [5:0]        seconds,
  output logic              sec_tick,
  output logic              ringing,
  output logic              play_sound,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic [1:0]        state_dbg
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int NW = $clog2(SNOOZE_MIN * 60 + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF  = PW'(TICKS_PER_SEC / 2);
  localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(DIGITS - 1);
  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECS - 1);
  localparam logic [NW-1:0] SNOOZE_LOAD = NW'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  // Control inputs are single-cycle pulses sampled on the clock edge; there is
  // no valid/ready handshake anywhere in this block.
  logic set_time;
  logic set_alarm;
  assign set_time  = (set_mode == 2'b01);
  assign set_alarm = (set_mode == 2'b10);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q;
  logic [IW-1:0] idx_q;
  logic [4:0]    hr_q, hr_d, al_hr_q, al_hr_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d, al_min_q, al_min_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [NW-1:0] snz_q, snz_d;
  alarm_state_e  state_q, state_d;
  logic          tick;
  logic          alarm_match;

  function automatic logic [5:0] wrap60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] wrap24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0001100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // The prescaler is frozen at zero while setting time so the first second
  // after leaving set mode is a full second long.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (set_time || presc_q == PRESC_LAST) begin
      presc_d = '0;
    end
  end

  assign tick = !set_time && (presc_q == PRESC_LAST);

  always_comb begin
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    if (set_time) begin
      sec_d = '0;
      if (inc_min) min_d = wrap60(min_q);
      if (inc_hr)  hr_d  = wrap24(hr_q);
    end else if (tick) begin
      sec_d = wrap60(sec_q);
      if (sec_q == 6'd59) begin
        min_d = wrap60(min_q);
        if (min_q == 6'd59) hr_d = wrap24(hr_q);
      end
    end
  end

  always_comb begin
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    if (set_alarm) begin
      if (inc_min) al_min_d = wrap60(al_min_q);
      if (inc_hr)  al_hr_d  = wrap24(al_hr_q);
    end
  end

  // Compared against the time as it will be after this edge.
  assign alarm_match = (sec_d == 6'd0) && (min_d == al_min_q) && (hr_d == al_hr_q);

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    case (state_q)
      IDLE: begin
        if (tick && alarm_match && alarm_en && !set_time) begin
          state_d = RINGING;
          ring_d  = '0;
        end
      end
      RINGING: begin
        if (stop) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d = SNOOZED;
          snz_d   = SNOOZE_LOAD;
        end else if (tick) begin
          if (ring_q == RING_LAST) state_d = IDLE;
          else                     ring_d  = ring_q + RW'(1);
        end
      end
      SNOOZED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick) begin
          // The tick that takes the countdown to zero re-rings.
          if (snz_q <= NW'(1)) begin
            snz_d   = '0;
            state_d = RINGING;
            ring_d  = '0;
          end else begin
            snz_d = snz_q - NW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!alarm_en || set_time) begin
      state_d = IDLE;
    end
  end

  logic [4:0]        disp_hr;
  logic [5:0]        disp_min;
  logic [5:0]        disp_sec;
  logic [2:0]        pos;
  logic [3:0]        digit;
  logic [DIGITS-1:0] one_hot;
  logic [DIGITS-1:0] an_d;
  logic              blank_d;

  // Digit positions are numbered S1..H10; a 4-digit display starts at M1.
  always_comb begin
    disp_hr  = set_alarm ? al_hr_q  : hr_q;
    disp_min = set_alarm ? al_min_q : min_q;
    disp_sec = set_alarm ? 6'd0     : sec_q;
    pos      = (DIGITS == 6) ? 3'(idx_q) : 3'(idx_q) + 3'd2;
    case (pos)
      3'd0:    digit = 4'(disp_sec % 6'd10);
      3'd1:    digit = 4'(disp_sec / 6'd10);
      3'd2:    digit = 4'(disp_min % 6'd10);
      3'd3:    digit = 4'(disp_min / 6'd10);
      3'd4:    digit = 4'(disp_hr % 5'd10);
      3'd5:    digit = 4'(disp_hr / 5'd10);
      default: digit = 4'd0;
    endcase
  end

  // Blanking looks at the next state/prescaler so it lines up with the
  // registered prescaler phase rather than trailing it by a cycle.
  always_comb begin
    one_hot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
    blank_d = (state_d == RINGING) && (presc_d >= PRESC_HALF);
    an_d    = blank_d ? {DIGITS{1'b1}} : ~one_hot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      hr_q     <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      al_hr_q  <= '0;
      al_min_q <= '0;
      state_q  <= IDLE;
      ring_q   <= '0;
      snz_q    <= '0;
      an       <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg      <= 7'b0000001;
    end else begin
      presc_q  <= presc_d;
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      al_hr_q  <= al_hr_d;
      al_min_q <= al_min_d;
      state_q  <= state_d;
      ring_q   <= ring_d;
      snz_q    <= snz_d;
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        scan_q <= scan_q + SW'(1);
      end
      an  <= an_d;
      seg <= seg_code(digit);
    end
  end

  assign hours      = hr_q;
  assign minutes    = min_q;
  assign seconds    = sec_q;
  assign sec_tick   = tick;
  assign ringing    = (state_q == RINGING);
  assign play_sound = ringing;
  assign state_dbg  = state_q;

endmodule

// File: doc/alarm_clock_core.md
Name: alarm_clock_core

Overview:
- Parametrised successor to the team's MM:SS seven-segment counter: a full HH:MM:SS timekeeper with a settable alarm, ring/snooze state machine and an N-digit multiplexed display driver, all on a single fast clock.
- `play_sound` drives the existing song player's `playSound` input directly.
- Replaces the separate divider, counter and display-mux instances with one clock-enabled block; there are no derived clocks.

Parameters:
- TICKS_PER_SEC, 100_000_000: clk cycles per second.
- SCAN_DIV, 125_000: clk cycles per display digit slot.
- DIGITS, 4: display digits, legal values 4 (HH:MM) or 6 (HH:MM:SS).
- RING_SECS, 60: seconds of ringing before auto-stop.
- SNOOZE_MIN, 5: snooze length in minutes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- set_mode  in  2  00 run, 01 set time, 10 set alarm, 11 treated as run.
- inc_hr  in  1  one-cycle pulse, increments hours of the selected target.
- inc_min  in  1  one-cycle pulse, increments minutes of the selected target.
- alarm_en  in  1  alarm armed.
- snooze  in  1  one-cycle pulse.
- stop  in  1  one-cycle pulse.
- hours  out  5  current hours, 0..23.
- minutes  out  6  current minutes, 0..59.
- seconds  out  6  current seconds, 0..59.
- sec_tick  out  1  one-cycle pulse per elapsed second.
- ringing  out  1  high in state RINGING.
- play_sound  out  1  equal to ringing; drives the song player.
- an  out  DIGITS  digit enables, active-low, one-hot.
- seg  out  7  segments, active-low, bit6=a … bit0=g.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; all state updates on posedge clk.
  - On reset:
    - time = 00:00:00, alarm = 00:00, prescaler = 0, scan counter and digit index = 0.
    - State = IDLE; sec_tick = 0, ringing = 0, play_sound = 0.
    - an = all ones except bit0 = 0; seg = 7'b0000001 (digit "0").
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 and wraps.
  - sec_tick = 1 in the cycle the count wraps, else 0.
- Time counting (set_mode 00, 10, 11), on sec_tick:
  - seconds +1; 59 -> 0 carries to minutes.
  - minutes 59 -> 0 carries to hours.
  - hours 23 -> 0.
  - 23:59:59 -> 00:00:00 in one tick.
- Set time (set_mode 01):
  - Prescaler, seconds and sec_tick held at 0.
  - inc_min: minutes +1, 59 -> 0, no carry to hours.
  - inc_hr: hours +1, 23 -> 0.
  - On return to run, the first sec_tick occurs TICKS_PER_SEC cycles later.
- Set alarm (set_mode 10):
  - Time keeps running.
  - inc_hr / inc_min adjust the alarm hours/minutes with the same wrap rules as set time.
- inc_hr / inc_min in run mode: ignored.
- Increment coinciding with a carry: in set alarm mode, inc_hr and inc_min touch only the alarm registers, so there is no conflict with time carries.
- Alarm FSM (IDLE, RINGING, SNOOZED):
  - IDLE -> RINGING when all of the following hold in the same cycle:
    - sec_tick = 1;
    - the post-update time equals alarm_hr:alarm_min:00;
    - alarm_en = 1;
    - set_mode != 01.
  - On entry to RINGING the ring second counter is cleared.
  - RINGING -> IDLE after RING_SECS sec_ticks, or on stop.
  - RINGING -> SNOOZED on snooze; the snooze counter loads SNOOZE_MIN*60.
  - SNOOZED: the snooze counter decrements on each sec_tick; at 0 -> RINGING (ring counter cleared).
  - stop in SNOOZED -> IDLE.
  - snooze in IDLE or SNOOZED: ignored.
  - snooze and stop in the same cycle: stop wins.
  - alarm_en = 0 in any state -> IDLE on the next edge.
  - Entering set_mode 01 while RINGING or SNOOZED -> IDLE.
  - Editing the alarm during SNOOZED does not alter the pending re-ring.
  - Time reaching alarm time while already RINGING or SNOOZED: no effect.
- Display:
  - Scan counter runs 0..SCAN_DIV-1; on wrap the digit index steps 0..DIGITS-1 and wraps.
  - an[idx] = 0, all other bits 1.
  - Digit 0 is the least-significant: DIGITS=4 shows M1 M10 H1 H10; DIGITS=6 shows S1 S10 M1 M10 H1 H10.
  - In set_mode 10 the alarm time is displayed, with seconds digits = 0.
  - When ringing and prescaler >= TICKS_PER_SEC/2, an = all ones (flash blanking).
  - Segment codes:

    | Digit | seg     |
    |-------|---------|
    | 0     | 0000001 |
    | 1     | 1001111 |
    | 2     | 0010010 |
    | 3     | 0000110 |
    | 4     | 1001100 |
    | 5     | 0100100 |
    | 6     | 0100000 |
    | 7     | 0001111 |
    | 8     | 0000000 |
    | 9     | 0001100 |

  - an and seg are registered: one cycle latency from an index change.

Test Plan:
Bench parameters: TICKS_PER_SEC=4, SCAN_DIV=2, RING_SECS=5, SNOOZE_MIN=1, DIGITS=6.
1. Rollover: set time to 23:59 (inc pulses in mode 01), run 59 ticks -> 23:59:59; next sec_tick -> 00:00:00, with sec_tick pulsing every 4 cycles.
2. Set-time hold and wrap: mode 01 with 60 inc_min pulses -> minutes back to the original value, hours unchanged; seconds = 0 throughout; first tick 4 cycles after return to 00.
3. Alarm fire and auto-stop:
   - alarm 00:01, alarm_en = 1, from 00:00:00 -> ringing = play_sound = 1 in the cycle time becomes 00:01:00;
   - after 5 ticks -> 0;
   - an = all ones during prescaler counts 2–3 while ringing.
4. Snooze, then stop: snooze while ringing -> ringing 0 for exactly 60 ticks, then 1 again; stop and snooze in the same cycle -> IDLE, no re-ring at 60 ticks.
5. Display scan: time 12:34:56 -> an cycles 111110 (seg 0100000), 111101 (0100100), … 011111 (1001111), each digit held for 2 cycles; mode 10 shows alarm with S digits 0000001.
6. Reset mid-ring: reset asserted while RINGING at 07:30:02 -> next edge: time 00:00:00, ringing 0, an = 111110, seg = 0000001.
